// File: rtl/banked_scratch_pad.sv
// Multi-port word-interleaved scratch pad: per-bank round-robin arbiters feed two-stage RAM
// pipelines (read / write / fetch-add), and reads return through credit-limited per-port FIFOs.
module banked_scratch_pad #(
    parameter int PORTS       = 8,
    parameter int BANKS       = 8,
    parameter int WIDTH       = 64,
    parameter int BANK_DEPTH  = 512,
    parameter int RESP_DEPTH  = 4,
    localparam int BANK_BITS  = $clog2(BANKS),
    localparam int ROW_BITS   = $clog2(BANK_DEPTH),
    localparam int ADDR_WIDTH = BANK_BITS + ROW_BITS
) (
    input  logic                        rst,
    input  logic                        clk,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    input  logic [2*PORTS-1:0]          req_op,
    input  logic [ADDR_WIDTH*PORTS-1:0] req_addr,
    input  logic [WIDTH*PORTS-1:0]      req_data,
    output logic [PORTS-1:0]            resp_valid,
    input  logic [PORTS-1:0]            resp_stall,
    output logic [WIDTH*PORTS-1:0]      resp_data
);
    localparam int PORT_BITS = $clog2(PORTS);
    localparam int CNT_BITS  = $clog2(RESP_DEPTH + 1);
    localparam int PTR_BITS  = $clog2(RESP_DEPTH);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FADD  = 2'b10;

    logic [1:0]            op_of      [PORTS];
    logic [ADDR_WIDTH-1:0] addr_of    [PORTS];
    logic [WIDTH-1:0]      data_of    [PORTS];
    logic                  eligible   [PORTS];
    logic                  port_valid [PORTS];
    logic [WIDTH-1:0]      port_data  [PORTS];
    logic [PORTS-1:0]      bank_grant [BANKS];
    logic                  push_valid [BANKS];
    logic [PORT_BITS-1:0]  push_port  [BANKS];
    logic [WIDTH-1:0]      push_data  [BANKS];

    // The reserved op is folded into a read so the rest of the design only sees three ops.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            op_of[i]   = (req_op[2*i +: 2] == 2'b11) ? OP_READ : req_op[2*i +: 2];
            addr_of[i] = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            data_of[i] = req_data[WIDTH*i +: WIDTH];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < PORTS; i++) begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_grant[b][i]) req_ready[i] = 1'b1;
            end
        end
        if (rst) req_ready = '0;
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        for (int i = 0; i < PORTS; i++) begin
            resp_valid[i]               = port_valid[i];
            resp_data[WIDTH*i +: WIDTH] = port_data[i];
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [PORTS-1:0]     cand;
        logic [PORT_BITS-1:0] rr, winner;
        logic                 found;
        logic [WIDTH-1:0]     mem [BANK_DEPTH];
        logic                 s1_valid, s2_valid, s2_bypass, s2_writes;
        logic [1:0]           s1_op, s2_op;
        logic [ROW_BITS-1:0]  s1_row, s2_row;
        logic [PORT_BITS-1:0] s1_port, s2_port;
        logic [WIDTH-1:0]     s1_data, s2_data, ram_q, wr_last, old, wr_val;

        always_comb begin
            cand = '0;
            for (int i = 0; i < PORTS; i++) begin
                cand[i] = req_valid[i] && eligible[i] &&
                          (addr_of[i][BANK_BITS-1:0] == BANK_BITS'(b));
            end
        end

        // Two passes pick the first candidate at or after rr without a modulo rotation.
        always_comb begin
            found  = 1'b0;
            winner = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (!found && cand[i] && (i >= int'(rr))) begin
                    found  = 1'b1;
                    winner = PORT_BITS'(i);
                end
            end
            for (int i = 0; i < PORTS; i++) begin
                if (!found && cand[i]) begin
                    found  = 1'b1;
                    winner = PORT_BITS'(i);
                end
            end
        end

        assign s2_writes     = s2_valid && (s2_op != OP_READ);
        assign old           = s2_bypass ? wr_last : ram_q;
        assign wr_val        = (s2_op == OP_FADD) ? old + s2_data : s2_data;
        assign bank_grant[b] = found ? (PORTS'(1) << winner) : '0;
        assign push_valid[b] = s2_valid && (s2_op != OP_WRITE);
        assign push_port[b]  = s2_port;
        assign push_data[b]  = old;

        always_ff @(posedge clk) begin
            if (rst) begin
                rr        <= '0;
                s1_valid  <= 1'b0;
                s2_valid  <= 1'b0;
                s2_bypass <= 1'b0;
            end else begin
                if (found) rr <= (winner == PORT_BITS'(PORTS - 1)) ? '0 : winner + PORT_BITS'(1);
                s1_valid  <= found;
                s2_valid  <= s1_valid;
                s2_bypass <= s1_valid && s2_writes && (s1_row == s2_row);
            end
        end

        // Payload and RAM carry no reset; the stage valids qualify them, and a write in S2
        // at the reset edge is dropped along with everything else in flight.
        always_ff @(posedge clk) begin
            if (found) begin
                s1_op   <= op_of[winner];
                s1_row  <= addr_of[winner][ADDR_WIDTH-1:BANK_BITS];
                s1_data <= data_of[winner];
                s1_port <= winner;
            end
            s2_op   <= s1_op;
            s2_row  <= s1_row;
            s2_data <= s1_data;
            s2_port <= s1_port;
            wr_last <= wr_val;
            ram_q   <= mem[s1_row];
            if (s2_writes && !rst) mem[s2_row] <= wr_val;
        end
    end

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        logic [WIDTH-1:0]    fifo [RESP_DEPTH];
        logic [PTR_BITS-1:0] head, tail;
        logic [CNT_BITS-1:0] count, outstanding;
        logic                push, pop, take;
        logic [WIDTH-1:0]    in_data;

        // Fixed pipeline latency means at most one bank retires a read for this port per cycle.
        always_comb begin
            push    = 1'b0;
            in_data = '0;
            for (int b = 0; b < BANKS; b++) begin
                if (push_valid[b] && (push_port[b] == PORT_BITS'(i))) begin
                    push    = 1'b1;
                    in_data = push_data[b];
                end
            end
        end

        assign pop           = (count != '0) && !resp_stall[i];
        assign take          = req_ready[i] && req_valid[i] && (op_of[i] != OP_WRITE);
        assign eligible[i]   = (op_of[i] == OP_WRITE) || (outstanding < CNT_BITS'(RESP_DEPTH));
        assign port_valid[i] = (count != '0);
        assign port_data[i]  = (count != '0) ? fifo[head] : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                outstanding <= '0;
            end else begin
                if (push) tail <= (tail == PTR_BITS'(RESP_DEPTH - 1)) ? '0 : tail + PTR_BITS'(1);
                if (pop)  head <= (head == PTR_BITS'(RESP_DEPTH - 1)) ? '0 : head + PTR_BITS'(1);
                count       <= count + CNT_BITS'(push) - CNT_BITS'(pop);
                outstanding <= outstanding + CNT_BITS'(take) - CNT_BITS'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (push) fifo[tail] <= in_data;
        end
    end
endmodule

// File: tb/tb_banked_scratch_pad.sv
// Directed and randomized bench for banked_scratch_pad against a transaction-level model:
// flat memory updated in acceptance order, per-port response queues with due cycles.
module tb_banked_scratch_pad;
    localparam int PORTS = 8;
    localparam int BANKS = 8;
    localparam int WIDTH = 64;
    localparam int RESP_DEPTH = 4;
    localparam int AW = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PORTS-1:0]       req_valid, req_ready, resp_valid, resp_stall;
    logic [2*PORTS-1:0]     req_op;
    logic [AW*PORTS-1:0]    req_addr;
    logic [WIDTH*PORTS-1:0] req_data, resp_data;

    banked_scratch_pad #(
        .PORTS(PORTS), .BANKS(BANKS), .WIDTH(WIDTH), .BANK_DEPTH(512), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .rst(rst), .clk(clk),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_stall(resp_stall), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               due;
    } resp_t;

    int               compared = 0;
    int               mismatched = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] ref_mem [1 << AW];
    int               rr_ref [BANKS];
    int               credits [PORTS];
    resp_t            resp_q [PORTS][$];
    logic [PORTS-1:0] seen_ready, seen_valid;
    logic [WIDTH-1:0] seen_data [PORTS];

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [1:0] op, input int addr, input logic [63:0] d);
        req_valid[p]             = v;
        req_op[2*p +: 2]         = op;
        req_addr[AW*p +: AW]     = AW'(addr);
        req_data[WIDTH*p +: WIDTH] = d;
    endtask

    task automatic idle_all();
        req_valid  = '0;
        req_op     = '0;
        req_addr   = '0;
        req_data   = '0;
        resp_stall = '0;
    endtask

    // One clock: predict grants and responses from the rules, compare, then advance the model.
    task automatic run_cycle();
        logic [PORTS-1:0] exp_ready, exp_valid;
        logic [1:0]       op;
        logic [63:0]      d;
        int               a, i, win;
        resp_t            e;
        #1;
        exp_ready = '0;
        exp_valid = '0;
        if (!rst) begin
            for (int b = 0; b < BANKS; b++) begin
                win = -1;
                for (int k = 0; k < PORTS; k++) begin
                    i  = (rr_ref[b] + k) % PORTS;
                    op = req_op[2*i +: 2];
                    a  = int'(req_addr[AW*i +: AW]);
                    if (win < 0 && req_valid[i] && (a % BANKS == b) && (op == 2'b01 || credits[i] < RESP_DEPTH))
                        win = i;
                end
                if (win >= 0) begin
                    exp_ready[win] = 1'b1;
                    rr_ref[b] = (win + 1) % PORTS;
                end
            end
            for (int p = 0; p < PORTS; p++)
                if (resp_q[p].size() > 0 && resp_q[p][0].due <= cyc) exp_valid[p] = 1'b1;
        end
        check_output("req_ready", 64'(req_ready), 64'(exp_ready));
        if (!rst) begin
            check_output("resp_valid", 64'(resp_valid), 64'(exp_valid));
            for (int p = 0; p < PORTS; p++)
                if (exp_valid[p])
                    check_output($sformatf("resp_data[%0d]", p), resp_data[WIDTH*p +: WIDTH], resp_q[p][0].data);
        end
        seen_ready = req_ready;
        seen_valid = resp_valid;
        for (int p = 0; p < PORTS; p++) seen_data[p] = resp_data[WIDTH*p +: WIDTH];
        if (rst) begin
            for (int p = 0; p < PORTS; p++) begin
                resp_q[p].delete();
                credits[p] = 0;
            end
            for (int b = 0; b < BANKS; b++) rr_ref[b] = 0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (exp_valid[p] && !resp_stall[p]) begin
                    void'(resp_q[p].pop_front());
                    credits[p]--;
                end
                if (exp_ready[p]) begin
                    op = req_op[2*p +: 2];
                    a  = int'(req_addr[AW*p +: AW]);
                    d  = req_data[WIDTH*p +: WIDTH];
                    if (op == 2'b01) begin
                        ref_mem[a] = d;
                    end else begin
                        e.data = ref_mem[a];
                        e.due  = cyc + 3;
                        resp_q[p].push_back(e);
                        credits[p]++;
                        if (op == 2'b10) ref_mem[a] = ref_mem[a] + d;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_stimulus(input int n);
        for (int c = 0; c < n; c++) run_cycle();
    endtask

    initial begin
        int accepts;
        for (int p = 0; p < PORTS; p++) credits[p] = 0;
        for (int b = 0; b < BANKS; b++) rr_ref[b] = 0;

        idle_all();
        rst = 1'b1;
        for (int p = 0; p < PORTS; p++) set_port(p, 1'b1, 2'b00, p, 64'd0);
        apply_stimulus(2);
        rst = 1'b0;
        idle_all();
        check_output("reset_resp_valid", 64'(resp_valid), 64'd0);
        check_output("reset_resp_data", 64'(|resp_data), 64'd0);

        // Initialise addresses 0..31 so later reads never touch unwritten RAM.
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < PORTS; p++) set_port(p, 1'b1, 2'b01, r*8 + p, {$urandom, $urandom});
            run_cycle();
            check_output("init_all_ready", 64'(seen_ready), 64'hFF);
        end
        idle_all();
        apply_stimulus(3);

        $display("[TB] write from port 2, read from port 5");
        set_port(2, 1'b1, 2'b01, 'h013, 64'hA5);
        run_cycle();
        check_output("wr_p2_ready", 64'(seen_ready[2]), 64'd1);
        idle_all();
        set_port(5, 1'b1, 2'b00, 'h013, 64'd0);
        run_cycle();
        check_output("rd_p5_ready", 64'(seen_ready[5]), 64'd1);
        idle_all();
        apply_stimulus(2);
        check_output("rd_p5_early", 64'(seen_valid[5]), 64'd0);
        run_cycle();
        check_output("rd_p5_valid", 64'(seen_valid[5]), 64'd1);
        check_output("rd_p5_data", seen_data[5], 64'hA5);
        apply_stimulus(2);

        $display("[TB] all ports hit distinct banks");
        for (int p = 0; p < PORTS; p++) set_port(p, 1'b1, 2'b00, 8 + p, 64'd0);
        run_cycle();
        check_output("par_ready", 64'(seen_ready), 64'hFF);
        idle_all();
        apply_stimulus(2);
        run_cycle();
        check_output("par_valid", 64'(seen_valid), 64'hFF);
        apply_stimulus(2);

        $display("[TB] back-to-back fetch-add");
        set_port(0, 1'b1, 2'b01, 'h040, 64'd10);
        run_cycle();
        set_port(0, 1'b1, 2'b10, 'h040, 64'd1);
        apply_stimulus(3);
        run_cycle();
        check_output("fadd_resp0", seen_data[0], 64'd10);
        set_port(0, 1'b1, 2'b00, 'h040, 64'd0);
        run_cycle();
        check_output("fadd_resp1", seen_data[0], 64'd11);
        idle_all();
        run_cycle();
        check_output("fadd_resp2", seen_data[0], 64'd12);
        run_cycle();
        check_output("fadd_resp3", seen_data[0], 64'd13);
        run_cycle();
        check_output("fadd_final_read", seen_data[0], 64'd14);
        apply_stimulus(2);

        $display("[TB] credit limit under consumer stall");
        accepts = 0;
        resp_stall[1] = 1'b1;
        set_port(1, 1'b1, 2'b00, 'h001, 64'd0);
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            accepts += int'(seen_ready[1]);
        end
        check_output("stall_accepts", 64'(accepts), 64'd4);
        check_output("stall_ready_low", 64'(seen_ready[1]), 64'd0);
        set_port(1, 1'b1, 2'b01, 'h009, 64'h1234);
        run_cycle();
        check_output("stall_write_ready", 64'(seen_ready[1]), 64'd1);
        set_port(1, 1'b1, 2'b00, 'h001, 64'd0);
        resp_stall[1] = 1'b0;
        apply_stimulus(10);
        idle_all();
        apply_stimulus(8);

        $display("[TB] round-robin on one bank");
        for (int k = 0; k < PORTS; k++) begin
            set_port(0, 1'b1, 2'b01, 3 + 8*k, 64'(k*3 + 1));
            run_cycle();
        end
        idle_all();
        apply_stimulus(4);
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        for (int p = 0; p < PORTS; p++) set_port(p, 1'b1, 2'b00, 3 + 8*p, 64'd0);
        for (int k = 0; k < 18; k++) begin
            run_cycle();
            check_output($sformatf("rr_grant_%0d", k), 64'(seen_ready), 64'(8'd1 << (k % 8)));
        end
        idle_all();
        apply_stimulus(12);

        $display("[TB] reset with reads in flight");
        set_port(3, 1'b1, 2'b00, 3, 64'd0);
        set_port(4, 1'b1, 2'b00, 4, 64'd0);
        set_port(5, 1'b1, 2'b00, 5, 64'd0);
        run_cycle();
        idle_all();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            check_output("post_reset_valid", 64'(seen_valid), 64'd0);
        end
        set_port(3, 1'b1, 2'b00, 3, 64'd0);
        run_cycle();
        check_output("post_reset_ready", 64'(seen_ready[3]), 64'd1);
        idle_all();
        apply_stimulus(2);
        run_cycle();
        check_output("post_reset_resp", 64'(seen_valid[3]), 64'd1);
        apply_stimulus(2);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                set_port(p, ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
                         int'($urandom_range(0, 31)), {$urandom, $urandom});
                resp_stall[p] = ($urandom_range(0, 99) < 25);
            end
            run_cycle();
        end
        idle_all();
        apply_stimulus(12);
        check_output("drain_valid", 64'(seen_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/banked_scratch_pad.md
# banked_scratch_pad

Multi-port banked on-chip scratch pad with a decoupled bank count, per-bank round-robin arbitration, and an atomic fetch-add mode. Each of PORTS requesters issues read, write or fetch-add requests with a valid/ready handshake. Requests are routed to BANKS word-interleaved single-port RAM banks. Read data returns through per-port credit-managed response FIFOs with consumer stall. It sits between accelerator lanes and local storage.

## Interface
- PORTS, 8: number of requester ports (≥2).
- BANKS, 8: number of RAM banks, power of two (≥2).
- WIDTH, 64: data word width.
- BANK_DEPTH, 512: words per bank, power of two.
- RESP_DEPTH, 4: per-port response FIFO depth and read-credit limit (≥3).
- BANK_BITS = log2(BANKS); ROW_BITS = log2(BANK_DEPTH); ADDR_WIDTH = BANK_BITS+ROW_BITS (derived).
- Port i of any flattened bus occupies bits [i*W +: W].

Ports:
- rst  in  1  synchronous, active-high reset.
- clk  in  1  clock; all state updates on rising edge.
- req_valid  in  PORTS  request present.
- req_ready  out  PORTS  request accepted this cycle when high with req_valid.
- req_op  in  2*PORTS  00 read, 01 write, 10 fetch-add, 11 reserved (treated as read).
- req_addr  in  ADDR_WIDTH*PORTS  word address; bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS].
- req_data  in  WIDTH*PORTS  write data / fetch-add increment.
- resp_valid  out  PORTS  response word available.
- resp_stall  in  PORTS  consumer not taking response; pop = resp_valid & ~resp_stall.
- resp_data  out  WIDTH*PORTS  read data, or pre-add value for fetch-add.

## Operation
- Arbitration: each bank has a round-robin pointer rr[b]. Candidates are ports with req_valid, bank match, and eligibility. Eligible means write op, or outstanding[i] < RESP_DEPTH. The bank grants the first candidate at or after rr[b] (modulo PORTS). On a grant, rr[b] ← grantee+1 (wraps PORTS-1→0). With no grant, rr[b] is unchanged.
- req_ready[i] = granted by the bank addressed by port i. It may depend combinationally on same-cycle req_valid/op/addr. It is 0 during rst.
- Credits: outstanding[i] increments on an accepted read/fetch-add and decrements on a response pop. Both in the same cycle leave it unchanged. Range is 0..RESP_DEPTH.
- Bank pipeline per bank:
  - S1: registered op/row/data/port; synchronous RAM read of row.
  - S2: old = bypass ? wr_last : ram_q.
    - Write: RAM[row] ← data.
    - Fetch-add: RAM[row] ← old+data (mod 2^WIDTH).
    - Read/fetch-add: push old into the FIFO of the issuing port.
- All RAM writes occur only in S2, so program order per bank is preserved.
- Bypass: set when the S1 row equals the S2 row and S2 performs a write. wr_last is the value S2 writes. This gives correct back-to-back fetch-add and read-after-write on the same row.
- Writes produce no response.
- Response FIFOs cannot overflow, because credits bound occupancy. Per-port order equals acceptance order: latency is fixed and at most one accept per port per cycle.

## Timing
- Request accepted in cycle T; S1 in T+1; S2 in T+2 (write visible to any read entering S1 from T+2).
- Read/fetch-add response: resp_valid earliest in T+3 when the FIFO is empty and unstalled. FIFO throughput is 1 pop/cycle/port.
- Each bank sustains 1 accept/cycle, so up to min(PORTS,BANKS) accepts/cycle total.
- Reset values: req_ready 0, resp_valid 0, resp_data 0, all rr 0, all outstanding 0, S1/S2 valid 0, FIFOs empty.
- RAM contents are not reset.
- Reset mid-operation drops in-flight requests and responses. Writes still in S1 at the reset edge are discarded.
- resp_stall held with a full FIFO: req_ready stays 0 for that port's reads; its writes are still accepted.

## Test plan
- Write 0xA5 to addr 0x013 from port 2, then read from port 5 → port 5 resp_data 0xA5, resp_valid 3 cycles after the read accept.
- All 8 ports read bank 3 (addrs 0x003,0x00B,…) continuously from reset → grants to ports 0,1,…,7 in consecutive cycles, then 0 again; one accept/cycle.
- Ports 0..7 each read a distinct bank in the same cycle → all 8 req_ready high together; 8 responses 3 cycles later.
- Addr 0x040 holds 10. Port 0 issues fetch-add +1 for 4 consecutive cycles → responses 10,11,12,13; a final read returns 14 (exercises bypass).
- Port 1 issues 6 reads with resp_stall=1 (RESP_DEPTH 4) → 4 accepted, req_ready[1]=0 afterward. A write from port 1 is still accepted. Release stall → 4 responses in order, then remaining reads accepted.
- Assert rst for 1 cycle with 3 reads in flight → no resp_valid afterward; outstanding 0; subsequent read accepted normally.
